// File: rtl/sd_card_pkg.sv
// Shared types and constants for the SD card-side command line engine.
// Holds the FSM encoding, frame geometry, CRC7 polynomial and STATUS bit map.
package sd_card_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_HOLD,
        ST_WAIT_RSP,
        ST_GAP,
        ST_TX
    } state_e;

    localparam int         CMD_FRAME_LEN = 48;
    localparam int         CMD_BODY_LEN  = 40;
    localparam logic [6:0] CRC7_POLY     = 7'h09;

    localparam int STAT_CRC_ERR  = 0;
    localparam int STAT_END_ERR  = 1;
    localparam int STAT_RX_BUSY  = 2;
    localparam int STAT_TX_BUSY  = 3;
    localparam int STAT_CMD_PEND = 4;

    // One serial step of CRC7 (x^7 + x^3 + 1), MSB-first data.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc_7.sv
// Serial CRC7 accumulator with synchronous clear (dominant) and enable.
// Shared between command reception and response transmission.
module sd_crc_7
    import sd_card_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    always_ff @(posedge clk) begin
        if (clr) begin
            crc <= 7'h00;
        end else if (en) begin
            crc <= crc7_step(crc, din);
        end
    end

endmodule

// File: rtl/sd_cmd_serial_card.sv
// Card-side SD CMD line engine: receives 48-bit host commands, hands them to a
// consumer, then drives the 48-bit response after an Ncr gap.
module sd_cmd_serial_card
    import sd_card_pkg::*;
#(
    parameter int NCR      = 2,
    parameter int STATUS_W = 8
) (
    input  logic                SD_CLK_IN,
    input  logic                RST_IN,
    input  logic                cmd_dat_i,
    output logic                cmd_out_o,
    output logic                cmd_oe_o,
    output logic [39:0]         CMD_OUT,
    output logic                REQ_OUT,
    input  logic                ACK_IN,
    input  logic [39:0]         RSP_IN,
    input  logic                RSP_REQ_IN,
    output logic                RSP_ACK_OUT,
    output logic [STATUS_W-1:0] STATUS
);

    localparam logic [5:0] LAST_BIT  = 6'(CMD_FRAME_LEN - 1);
    localparam logic [5:0] BODY_LAST = 6'(CMD_BODY_LEN - 1);
    localparam logic [5:0] CRC_LAST  = 6'(CMD_FRAME_LEN - 2);
    localparam logic [5:0] NCR_C     = 6'(NCR);
    localparam logic [5:0] NCR_M1    = 6'(NCR - 1);

    state_e      state_q, state_d;
    logic [5:0]  bit_cnt_q;
    logic [5:0]  end_cnt_q;
    logic [5:0]  gap_cnt_q;
    logic [39:0] rx_sr_q;
    logic [6:0]  rx_crc_q;
    logic [39:0] rsp_sr_q;
    logic [39:0] cmd_q;
    logic        crc_err_q, end_err_q, rsp_ack_q;

    logic [6:0]  crc_val;
    logic        crc_clr, crc_en, crc_din;
    logic [2:0]  crc_idx;
    logic        rx_last, tx_last, crc_ok, fmt_ok, gap_armed, tx_bit;

    assign rx_last   = (state_q == ST_RX) && (bit_cnt_q == LAST_BIT);
    assign tx_last   = (state_q == ST_TX) && (bit_cnt_q == LAST_BIT);
    assign crc_ok    = (rx_crc_q == crc_val);
    assign fmt_ok    = cmd_dat_i && rx_sr_q[38];
    // The gap only starts counting once Ncr cycles have passed since the end bit.
    assign gap_armed = (end_cnt_q == NCR_C);
    assign crc_idx   = 3'd6 - bit_cnt_q[2:0];

    assign crc_clr = RST_IN || !((state_q == ST_RX) || (state_q == ST_TX));
    assign crc_en  = ((state_q == ST_RX) || (state_q == ST_TX)) && (bit_cnt_q <= BODY_LAST);
    assign crc_din = (state_q == ST_RX) ? cmd_dat_i : rsp_sr_q[39];

    sd_crc_7 u_crc (
        .clk (SD_CLK_IN),
        .clr (crc_clr),
        .en  (crc_en),
        .din (crc_din),
        .crc (crc_val)
    );

    always_ff @(posedge SD_CLK_IN) begin
        if (RST_IN) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (!cmd_dat_i) state_d = ST_RX;
            ST_RX:       if (rx_last) state_d = (crc_ok && fmt_ok) ? ST_HOLD : ST_IDLE;
            ST_HOLD:     if (ACK_IN) state_d = ST_WAIT_RSP;
            ST_WAIT_RSP: begin
                if (RSP_REQ_IN)      state_d = ST_GAP;
                else if (!cmd_dat_i) state_d = ST_RX;
            end
            ST_GAP:      if (gap_armed && (gap_cnt_q == NCR_M1)) state_d = ST_TX;
            ST_TX:       if (tx_last) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_bit = 1'b1;
        if (bit_cnt_q <= BODY_LAST)     tx_bit = rsp_sr_q[39];
        else if (bit_cnt_q <= CRC_LAST) tx_bit = crc_val[crc_idx];
        cmd_oe_o  = ((state_q == ST_GAP) && gap_armed) || (state_q == ST_TX);
        cmd_out_o = (state_q == ST_TX) ? tx_bit : 1'b1;
    end

    always_ff @(posedge SD_CLK_IN) begin
        if (RST_IN) begin
            bit_cnt_q <= '0;
            end_cnt_q <= '0;
            gap_cnt_q <= '0;
            cmd_q     <= '0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
            rsp_ack_q <= 1'b0;
        end else begin
            rsp_ack_q <= tx_last;
            if (rx_last)                end_cnt_q <= '0;
            else if (end_cnt_q != NCR_C) end_cnt_q <= end_cnt_q + 6'd1;
            case (state_q)
                ST_IDLE, ST_WAIT_RSP: begin
                    bit_cnt_q <= 6'd1;
                    gap_cnt_q <= '0;
                    rx_sr_q   <= '0;
                    if (state_q == ST_WAIT_RSP && RSP_REQ_IN) rsp_sr_q <= RSP_IN;
                end
                ST_RX: begin
                    bit_cnt_q <= bit_cnt_q + 6'd1;
                    if (bit_cnt_q <= BODY_LAST)     rx_sr_q  <= {rx_sr_q[38:0], cmd_dat_i};
                    else if (bit_cnt_q <= CRC_LAST) rx_crc_q <= {rx_crc_q[5:0], cmd_dat_i};
                    if (rx_last) begin
                        if (crc_ok && fmt_ok) begin
                            cmd_q     <= rx_sr_q;
                            crc_err_q <= 1'b0;
                            end_err_q <= 1'b0;
                        end else begin
                            crc_err_q <= !crc_ok;
                            end_err_q <= !fmt_ok;
                        end
                    end
                end
                ST_GAP: begin
                    bit_cnt_q <= '0;
                    if (gap_armed) gap_cnt_q <= gap_cnt_q + 6'd1;
                end
                ST_TX: begin
                    bit_cnt_q <= bit_cnt_q + 6'd1;
                    if (bit_cnt_q <= BODY_LAST) rsp_sr_q <= {rsp_sr_q[38:0], 1'b0};
                end
                default: ;
            endcase
        end
    end

    assign CMD_OUT     = cmd_q;
    assign REQ_OUT     = (state_q == ST_HOLD);
    assign RSP_ACK_OUT = rsp_ack_q;

    always_comb begin
        STATUS                = '0;
        STATUS[STAT_CRC_ERR]  = crc_err_q;
        STATUS[STAT_END_ERR]  = end_err_q;
        STATUS[STAT_RX_BUSY]  = (state_q == ST_RX);
        STATUS[STAT_TX_BUSY]  = (state_q == ST_GAP) || (state_q == ST_TX);
        STATUS[STAT_CMD_PEND] = REQ_OUT;
    end

endmodule

// File: tb/tb_sd_cmd_serial_card.sv
// Directed bench for sd_cmd_serial_card: command reception, error flags,
// response timing/CRC, reset aborts and commands arriving while awaiting a response.
module tb_sd_cmd_serial_card;

    logic        SD_CLK_IN  = 1'b0;
    logic        RST_IN     = 1'b1;
    logic        cmd_dat_i  = 1'b1;
    logic        ACK_IN     = 1'b0;
    logic        RSP_REQ_IN = 1'b0;
    logic [39:0] RSP_IN     = '0;
    logic        cmd_out_o, cmd_oe_o, REQ_OUT, RSP_ACK_OUT;
    logic [39:0] CMD_OUT;
    logic [7:0]  STATUS;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [47:0] F_CMD0        = 48'h400000000095;
    localparam logic [47:0] F_CMD8        = 48'h48000001AA87;
    localparam logic [47:0] F_CMD8_BADCRC = 48'h48000001AA85;
    localparam logic [47:0] F_CMD8_BADEND = 48'h48000001AA86;

    sd_cmd_serial_card #(.NCR(2), .STATUS_W(8)) dut (
        .SD_CLK_IN   (SD_CLK_IN),
        .RST_IN      (RST_IN),
        .cmd_dat_i   (cmd_dat_i),
        .cmd_out_o   (cmd_out_o),
        .cmd_oe_o    (cmd_oe_o),
        .CMD_OUT     (CMD_OUT),
        .REQ_OUT     (REQ_OUT),
        .ACK_IN      (ACK_IN),
        .RSP_IN      (RSP_IN),
        .RSP_REQ_IN  (RSP_REQ_IN),
        .RSP_ACK_OUT (RSP_ACK_OUT),
        .STATUS      (STATUS)
    );

    always #5 SD_CLK_IN = ~SD_CLK_IN;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge SD_CLK_IN);
            #1;
        end
    endtask

    task automatic send_bits(input logic [47:0] f, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            cmd_dat_i = f[i];
            tick(1);
        end
    endtask

    task automatic send_frame(input logic [47:0] f);
        send_bits(f, 47, 0);
        cmd_dat_i = 1'b1;
    endtask

    task automatic pulse_ack();
        ACK_IN = 1'b1;
        tick(1);
        ACK_IN = 1'b0;
    endtask

    logic [47:0] got;
    logic [47:0] exp_rsp;
    int          acks;
    int          oe_seen;
    int          oe_all;

    initial begin
        // Reset state
        tick(3);
        chk("rst_req", REQ_OUT, 0);
        chk("rst_cmd_out", CMD_OUT, 0);
        chk("rst_status", STATUS, 0);
        chk("rst_oe", cmd_oe_o, 0);
        chk("rst_out", cmd_out_o, 1);
        chk("rst_ack", RSP_ACK_OUT, 0);
        RST_IN = 1'b0;
        tick(2);

        // CMD0: REQ_OUT rises exactly one cycle after the end bit
        send_bits(F_CMD0, 47, 1);
        chk("cmd0_req_before_end", REQ_OUT, 0);
        chk("cmd0_rx_busy", STATUS, 8'h04);
        send_bits(F_CMD0, 0, 0);
        cmd_dat_i = 1'b1;
        chk("cmd0_req", REQ_OUT, 1);
        chk("cmd0_cmd_out", CMD_OUT, 40'h4000000000);
        chk("cmd0_status", STATUS, 8'h10);

        // RSP_REQ_IN ignored while holding; command stays stable
        RSP_IN     = 40'h1234567890;
        RSP_REQ_IN = 1'b1;
        tick(1);
        RSP_REQ_IN = 1'b0;
        tick(2);
        chk("hold_no_oe", cmd_oe_o, 0);
        chk("hold_req_stable", REQ_OUT, 1);
        chk("hold_cmd_stable", CMD_OUT, 40'h4000000000);

        // ACK together with a start bit: start bit not captured
        ACK_IN    = 1'b1;
        cmd_dat_i = 1'b0;
        tick(1);
        ACK_IN    = 1'b0;
        cmd_dat_i = 1'b1;
        chk("ack_req_low", REQ_OUT, 0);
        chk("ack_start_ignored", STATUS, 8'h00);
        tick(2);
        chk("wait_status", STATUS, 8'h00);
        chk("wait_no_oe", cmd_oe_o, 0);

        // New command while waiting for a response: captured, nothing sent
        send_frame(F_CMD0);
        chk("wait_cmd0_req", REQ_OUT, 1);
        chk("wait_cmd0_cmd", CMD_OUT, 40'h4000000000);
        oe_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (cmd_oe_o) oe_seen++;
            tick(1);
        end
        chk("wait_cmd0_no_rsp", oe_seen, 0);
        pulse_ack();

        // Corrupted CRC, then bad end bit
        send_frame(F_CMD8_BADCRC);
        chk("badcrc_req", REQ_OUT, 0);
        chk("badcrc_status", STATUS, 8'h01);
        tick(3);
        chk("badcrc_idle", STATUS, 8'h01);
        send_frame(F_CMD8_BADEND);
        chk("badend_req", REQ_OUT, 0);
        chk("badend_status", STATUS, 8'h02);

        // Good CMD8 clears the error flags
        send_frame(F_CMD8);
        chk("cmd8_req", REQ_OUT, 1);
        chk("cmd8_status", STATUS, 8'h10);
        chk("cmd8_cmd_out", CMD_OUT, 40'h48000001AA);
        tick(5);
        pulse_ack();
        chk("cmd8_ack_req", REQ_OUT, 0);
        chk("cmd8_pre_oe", cmd_oe_o, 0);

        // Response: Ncr=2 gap cycles driven high, then 48 bits
        RSP_IN     = 40'h08000001AA;
        RSP_REQ_IN = 1'b1;
        tick(1);
        RSP_REQ_IN = 1'b0;
        chk("gap1_oe", cmd_oe_o, 1);
        chk("gap1_out", cmd_out_o, 1);
        chk("gap1_status", STATUS, 8'h08);
        tick(1);
        chk("gap2_oe", cmd_oe_o, 1);
        chk("gap2_out", cmd_out_o, 1);
        tick(1);
        acks   = 0;
        oe_all = 1;
        for (int i = 0; i < 48; i++) begin
            if (!cmd_oe_o) oe_all = 0;
            got[47-i] = cmd_out_o;
            if (RSP_ACK_OUT) acks++;
            tick(1);
        end
        exp_rsp = {40'h08000001AA, crc7(40'h08000001AA), 1'b1};
        chk("rsp_frame", got, exp_rsp);
        chk("rsp_end_bit", got[0], 1);
        chk("rsp_oe_throughout", oe_all, 1);
        chk("rsp_no_early_ack", acks, 0);
        chk("rsp_done_oe", cmd_oe_o, 0);
        chk("rsp_done_ack", RSP_ACK_OUT, 1);
        chk("rsp_done_out", cmd_out_o, 1);
        chk("rsp_done_status", STATUS, 8'h00);
        tick(1);
        chk("rsp_ack_pulse_end", RSP_ACK_OUT, 0);

        // Reset at TX bit 20 aborts the response
        send_frame(F_CMD0);
        pulse_ack();
        RSP_IN     = 40'hA5C3F00F5A;
        RSP_REQ_IN = 1'b1;
        tick(1);
        RSP_REQ_IN = 1'b0;
        tick(2);
        tick(20);
        chk("tx20_oe", cmd_oe_o, 1);
        RST_IN = 1'b1;
        tick(1);
        chk("txrst_oe", cmd_oe_o, 0);
        chk("txrst_out", cmd_out_o, 1);
        chk("txrst_ack", RSP_ACK_OUT, 0);
        chk("txrst_status", STATUS, 8'h00);
        chk("txrst_req", REQ_OUT, 0);
        RST_IN  = 1'b0;
        acks    = 0;
        oe_seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (RSP_ACK_OUT) acks++;
            if (cmd_oe_o) oe_seen++;
            tick(1);
        end
        chk("txrst_no_ack_after", acks, 0);
        chk("txrst_no_oe_after", oe_seen, 0);
        send_frame(F_CMD0);
        chk("post_rst_req", REQ_OUT, 1);
        chk("post_rst_cmd", CMD_OUT, 40'h4000000000);

        // Reset mid-RX aborts the frame
        pulse_ack();
        send_bits(F_CMD8, 47, 28);
        chk("rxmid_busy", STATUS, 8'h04);
        RST_IN    = 1'b1;
        cmd_dat_i = 1'b1;
        tick(1);
        chk("rxrst_status", STATUS, 8'h00);
        chk("rxrst_req", REQ_OUT, 0);
        chk("rxrst_cmd", CMD_OUT, 0);
        RST_IN = 1'b0;
        tick(2);
        send_frame(F_CMD8);
        chk("post_rxrst_req", REQ_OUT, 1);
        chk("post_rxrst_cmd", CMD_OUT, 40'h48000001AA);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
